ledda_cfg_writer: RTL
=====================

# ledda_cfg_writer

Register-bus initiator for the iCE40 `SB_LEDDA_IP` LED PWM/breathe hard block. It accepts one complete LED configuration over a valid/ready handshake. It then serialises that configuration as nine register writes on the LEDDA bus (`LEDDCS`/`LEDDDEN`/`LEDDADDR`/`LEDDDAT`) and finally drives `LEDDEXE`. It sits between the deck's status logic and the LEDDA primitive; at top level `LEDDCLK` is tied to `clk`.

## Interface
- `GAP_CYCLES`, 1: idle cycles with `ledd_den` low after each write pulse; range 1–15.
- `FR250`, 0: value written to LEDDCR0 bit 6.
- `OUTPOL`, 0: value written to LEDDCR0 bit 5.

- `clk`  in  1  system clock; also feeds LEDDCLK.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  block idle; configuration accepted when valid && ready at a rising edge.
- `cfg_run`  in  1  value applied to `ledd_exe` after the sequence.
- `cfg_prescale`  in  10  LEDDA clock prescaler.
- `cfg_on_time`, `cfg_off_time`  in  8 each  blink on/off times.
- `cfg_breathe_en`  in  1  breathe enable.
- `cfg_breathe_rate`  in  4  breathe rate.
- `cfg_pwm_r`, `cfg_pwm_g`, `cfg_pwm_b`  in  8 each  duty cycles.
- `ledd_cs`  out  1  to LEDDCS.
- `ledd_den`  out  1  to LEDDDEN.
- `ledd_addr`  out  4  to LEDDADDR3..0.
- `ledd_dat`  out  8  to LEDDDAT7..0.
- `ledd_exe`  out  1  to LEDDEXE.
- `ledd_rst`  out  1  to LEDDRST.
- `busy`  out  1  equals !cfg_ready.

## Operation
- All `cfg_*` fields are latched into internal registers on accept. Inputs are ignored at all other times.
- FSM states:
  - IDLE → SETUP on accept.
  - SETUP: 1 cycle, cs=1, den=0.
  - WRITE: 1 cycle, den=1.
  - GAP: GAP_CYCLES cycles, den=0.
  - After GAP, go back to WRITE while the write index is below 8. Otherwise go to END.
  - END: 1 cycle, cs=0.
  - END → IDLE.
- The write index is a 4-bit counter: cleared in SETUP, incremented on leaving GAP.
- Write order (index: addr, data):
  - 0: 4'h8 LEDDCR0 = {1, FR250, OUTPOL, 0, 0, 0, prescale[9:8]}
  - 1: 4'h9 LEDDBR = prescale[7:0]
  - 2: 4'hA ONR = on_time
  - 3: 4'hB OFR = off_time
  - 4: 4'h5 BCRR = {breathe_en, 3'b000, rate}
  - 5: 4'h6 BCFR = same value as BCRR
  - 6: 4'h1 PWRR = pwm_r
  - 7: 4'h2 PWRG = pwm_g
  - 8: 4'h3 PWRB = pwm_b
- `ledd_addr`/`ledd_dat` are set at entry to WRITE and held unchanged through the following GAP. In IDLE they return to 0.
- `ledd_exe` keeps its previous value during the whole sequence. It is loaded from the latched `cfg_run` in END.
- `ledd_rst` is a registered copy of `reset`.
- `cfg_ready` = (state == IDLE) && !reset && !ledd_rst.

## Timing
- All outputs are registered except `cfg_ready`/`busy`, which are decoded from state.
- Reset values: cs=0, den=0, addr=0, dat=0, exe=0, rst=1, state=IDLE.
- `cfg_ready` is 0 on the first cycle after reset deasserts, because `ledd_rst` is still 1. It is 1 from the cycle after that.
- Accept at edge k:
  - cs=1 from k+1.
  - First den pulse at k+2.
  - Write i pulse at k+2+i·(1+GAP_CYCLES).
  - END at k+2+9·(1+GAP_CYCLES); exe and cs=0 take effect then.
  - cfg_ready=1 one cycle later.
  - Total busy with GAP_CYCLES=1: 20 cycles.
- `ledd_den` is never high in two consecutive cycles. `ledd_cs` is high throughout every den pulse.
- `cfg_valid` asserted while busy is not accepted and must be held by the source. Back-to-back accept is possible on the first ready cycle.
- Reset mid-sequence: the next edge forces all reset values. The remaining writes are abandoned and nothing resumes afterwards.
- Latched fields are stable for the whole sequence, independent of input changes.

## Test plan
- Reset release: reset high 3 cycles, then low → rst=1 until the first edge after release; ready=0 for one further cycle, then 1; all other outputs at reset values.
- Single config: prescale=10'h2A5, on=8'h10, off=8'h20, breathe_en=1, rate=4'h7, pwm=8'hFF/8'h80/8'h00, run=1, GAP_CYCLES=1 → exactly 9 den pulses, (addr,dat) = (8,8'h82), (9,8'hA5), (A,10), (B,20), (5,87), (6,87), (1,FF), (2,80), (3,00), each 2 cycles apart; exe rises in END; ready back after 20 busy cycles.
- Backpressure: valid held across a busy period with changing data → only the first config is written; second accepted on the first ready cycle; its writes reflect the values present at its accept edge.
- Reset mid-operation: assert reset during write index 4 → next cycle cs=0, den=0, exe=0; no further den pulses.
- GAP_CYCLES=3: den pulses spaced 4 cycles; total busy 38 cycles; addr/dat stable throughout each gap.
- Run toggle: second config with run=0 → exe stays 1 during writes and drops only in END.

Source files
------------

// File: rtl/ledda_cfg_writer.sv
// ledda_cfg_writer
//   Register-bus initiator for the iCE40 SB_LEDDA_IP block. Accepts one LED
//   configuration over valid/ready, then issues nine register writes on the
//   LEDDA bus (cs/den/addr/dat) and finally loads ledd_exe from cfg_run.
//
// Parameters
//   GAP_CYCLES : idle cycles (den low) after each write pulse, 1..15
//   FR250      : LEDDCR0 bit 6
//   OUTPOL     : LEDDCR0 bit 5
//
// Ports
//   clk, reset            : clock (also LEDDCLK) and synchronous active-high reset
//   cfg_valid / cfg_ready : configuration handshake; busy = !cfg_ready
//   cfg_*                 : configuration fields, latched on accept
//   ledd_cs/den/addr/dat  : LEDDA register bus
//   ledd_exe, ledd_rst    : LEDDEXE and LEDDRST
module ledda_cfg_writer #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          FR250      = 1'b0,
    parameter bit          OUTPOL     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_run,
    input  logic [9:0] cfg_prescale,
    input  logic [7:0] cfg_on_time,
    input  logic [7:0] cfg_off_time,
    input  logic       cfg_breathe_en,
    input  logic [3:0] cfg_breathe_rate,
    input  logic [7:0] cfg_pwm_r,
    input  logic [7:0] cfg_pwm_g,
    input  logic [7:0] cfg_pwm_b,
    output logic       ledd_cs,
    output logic       ledd_den,
    output logic [3:0] ledd_addr,
    output logic [7:0] ledd_dat,
    output logic       ledd_exe,
    output logic       ledd_rst,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_GAP,
        S_END
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [3:0]  gap_cnt;
    logic        accept;
    logic        gap_done;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_dat;

    logic        run_q;
    logic [9:0]  prescale_q;
    logic [7:0]  on_q, off_q;
    logic        ben_q;
    logic [3:0]  rate_q;
    logic [7:0]  pwm_r_q, pwm_g_q, pwm_b_q;

    assign cfg_ready = (state == S_IDLE) && !reset && !ledd_rst;
    assign busy      = !cfg_ready;
    assign accept    = cfg_valid && cfg_ready;
    assign gap_done  = (gap_cnt == 4'(GAP_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SETUP;
            S_SETUP: begin
                idx_nxt   = '0;
                state_nxt = S_WRITE;
            end
            S_WRITE: state_nxt = S_GAP;
            S_GAP: begin
                if (gap_done) begin
                    idx_nxt   = idx + 4'd1;
                    state_nxt = (idx < 4'd8) ? S_WRITE : S_END;
                end
            end
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Selected by the index the write is about to use, so the registered
    // addr/dat line up with the den pulse.
    always_comb begin
        wr_addr = '0;
        wr_dat  = '0;
        case (idx_nxt)
            4'd0: begin wr_addr = 4'h8; wr_dat = {1'b1, FR250, OUTPOL, 3'b000, prescale_q[9:8]}; end
            4'd1: begin wr_addr = 4'h9; wr_dat = prescale_q[7:0]; end
            4'd2: begin wr_addr = 4'hA; wr_dat = on_q; end
            4'd3: begin wr_addr = 4'hB; wr_dat = off_q; end
            4'd4: begin wr_addr = 4'h5; wr_dat = {ben_q, 3'b000, rate_q}; end
            4'd5: begin wr_addr = 4'h6; wr_dat = {ben_q, 3'b000, rate_q}; end
            4'd6: begin wr_addr = 4'h1; wr_dat = pwm_r_q; end
            4'd7: begin wr_addr = 4'h2; wr_dat = pwm_g_q; end
            4'd8: begin wr_addr = 4'h3; wr_dat = pwm_b_q; end
            default: begin wr_addr = '0; wr_dat = '0; end
        endcase
    end

    // Bus outputs are registered from the next state so each takes effect in
    // the cycle its state is entered.
    always_ff @(posedge clk) begin
        ledd_rst <= reset;
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            ledd_cs   <= 1'b0;
            ledd_den  <= 1'b0;
            ledd_addr <= '0;
            ledd_dat  <= '0;
            ledd_exe  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            gap_cnt  <= (state == S_GAP) ? gap_cnt + 4'd1 : '0;
            ledd_cs  <= (state_nxt == S_SETUP) || (state_nxt == S_WRITE) || (state_nxt == S_GAP);
            ledd_den <= (state_nxt == S_WRITE);
            if (state_nxt == S_WRITE) begin
                ledd_addr <= wr_addr;
                ledd_dat  <= wr_dat;
            end else if (state_nxt == S_IDLE) begin
                ledd_addr <= '0;
                ledd_dat  <= '0;
            end
            if (state_nxt == S_END) ledd_exe <= run_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            run_q      <= cfg_run;
            prescale_q <= cfg_prescale;
            on_q       <= cfg_on_time;
            off_q      <= cfg_off_time;
            ben_q      <= cfg_breathe_en;
            rate_q     <= cfg_breathe_rate;
            pwm_r_q    <= cfg_pwm_r;
            pwm_g_q    <= cfg_pwm_g;
            pwm_b_q    <= cfg_pwm_b;
        end
    end

endmodule
